// File: rtl/conv_pkg.sv
// Shared constants and pad FSM state encoding for the 3x3 convolver front end.
package conv_pkg;

  localparam int PIXEL_DATAW  = 8;
  localparam int IMAGE_WIDTH  = 512;
  localparam int PADDED_WIDTH = IMAGE_WIDTH + 2;
  localparam int FILTER_SIZE  = 3;

  typedef enum logic [2:0] {
    TOP,
    LEFT,
    BODY,
    RIGHT,
    BOTTOM
  } pad_state_t;

endpackage

// File: rtl/conv_pad.sv
// Wraps each raw frame in a one-pixel zero border; one register stage, 1-cycle latency.
// Backpressure: the output register holds while o_valid && !i_ready; raw pixels accepted only in BODY.
module conv_pad
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH = conv_pkg::IMAGE_WIDTH,
  parameter int PIXEL_DATAW = conv_pkg::PIXEL_DATAW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [PIXEL_DATAW-1:0] i_x,
  input  logic                   i_last,
  output logic                   o_ready,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [PIXEL_DATAW-1:0] o_x,
  output logic                   o_last
);

  localparam int PAD_W = IMAGE_WIDTH + 2;
  localparam int COL_W = $clog2(PAD_W);
  localparam logic [COL_W-1:0] COL_END      = COL_W'(PAD_W - 1);
  localparam logic [COL_W-1:0] COL_DATA_END = COL_W'(IMAGE_WIDTH);
  localparam logic [COL_W-1:0] COL_ONE      = COL_W'(1);

  pad_state_t       state;
  logic [COL_W-1:0] col;
  logic             last_row;
  logic             advance;
  logic             in_xfer;

  assign advance = !o_valid || i_ready;
  assign o_ready = (state == BODY) && advance;
  assign in_xfer = i_valid && o_ready;

  // col tracks the padded column: LEFT is 0, data is 1..IMAGE_WIDTH, RIGHT is IMAGE_WIDTH+1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= TOP;
      col      <= '0;
      last_row <= 1'b0;
      o_valid  <= 1'b0;
      o_x      <= '0;
      o_last   <= 1'b0;
    end else if (advance) begin
      o_valid <= 1'b1;
      o_x     <= '0;
      o_last  <= 1'b0;
      case (state)
        TOP: begin
          if (col == COL_END) begin
            col   <= '0;
            state <= LEFT;
          end else begin
            col <= col + COL_ONE;
          end
        end
        LEFT: begin
          col   <= col + COL_ONE;
          state <= BODY;
        end
        BODY: begin
          if (in_xfer) begin
            o_x <= i_x;
            col <= col + COL_ONE;
            // Only the row's final pixel decides whether this was the last row.
            if (col == COL_DATA_END) begin
              last_row <= i_last;
              state    <= RIGHT;
            end
          end else begin
            o_valid <= 1'b0;
          end
        end
        RIGHT: begin
          col   <= '0;
          state <= last_row ? BOTTOM : LEFT;
        end
        BOTTOM: begin
          if (col == COL_END) begin
            col    <= '0;
            o_last <= 1'b1;
            state  <= TOP;
          end else begin
            col <= col + COL_ONE;
          end
        end
        default: begin
          col     <= '0;
          o_valid <= 1'b0;
          state   <= TOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pad.sv
// Random-handshake bench for conv_pad: a frame-level padding model feeds an expected-beat queue.
module tb_conv_pad;

  localparam int W  = 512;
  localparam int PW = W + 2;

  typedef struct {
    int x;
    bit last;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_valid;
  logic [7:0] i_x;
  logic       i_last;
  logic       o_ready;
  logic       i_ready;
  logic       o_valid;
  logic [7:0] o_x;
  logic       o_last;

  always #5 clk = ~clk;

  conv_pad #(.IMAGE_WIDTH(W), .PIXEL_DATAW(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_valid(i_valid),
    .i_x    (i_x),
    .i_last (i_last),
    .o_ready(o_ready),
    .i_ready(i_ready),
    .o_valid(o_valid),
    .o_x    (o_x),
    .o_last (o_last)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  beat_t      exp_q[$];
  int         exp_h[$];
  logic [7:0] frame_pix[$];
  bit         rand_rdy = 1'b0;
  bit         rand_vld = 1'b0;
  bit         mon_en = 1'b0;
  int         beats = 0;
  int         last_cnt = 0;
  bit         prev_stall = 1'b0;
  bit         after_last = 1'b0;
  logic [7:0] prev_x;
  logic       prev_last;

  // A fresh output stream always starts with the top zero row plus the next left border.
  function automatic void push_lead();
    for (int c = 0; c < PW + 1; c++) exp_q.push_back('{0, 1'b0});
  endfunction

  function automatic void model_frame(input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < W; c++) exp_q.push_back('{int'(frame_pix[r*W+c]), 1'b0});
      exp_q.push_back('{0, 1'b0});
      if (r < h - 1) exp_q.push_back('{0, 1'b0});
      else begin
        for (int c = 0; c < PW; c++) exp_q.push_back('{0, c == PW - 1});
        push_lead();
      end
    end
    exp_h.push_back(h);
  endfunction

  function automatic void fill(input int h, input bit rnd);
    frame_pix.delete();
    for (int p = 0; p < h * W; p++)
      frame_pix.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'((p % W) & 255));
  endfunction

  task automatic do_reset();
    int cnt;
    mon_en  = 1'b0;
    reset   = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_h.delete();
    push_lead();
    beats      = 0;
    prev_stall = 1'b0;
    after_last = 1'b0;
    mon_en     = 1'b1;
    @(negedge clk);
    check("rst_ovalid", o_valid, 0);
    check("rst_oready", o_ready, 0);
    check("rst_ox", o_x, 0);
    check("rst_olast", o_last, 0);
    cnt = 1;
    while (cnt < 2000) begin
      @(negedge clk);
      if (o_ready) break;
      cnt++;
    end
    check("rst_oready_low_cycles", cnt, PW + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int h, input int gap_at, input int rst_at, input int fake_last_at);
    int t;
    for (int p = 0; p < h * W; p++) begin
      if (p == rst_at) begin
        do_reset();
        return;
      end
      if (rand_vld) begin
        while ($urandom_range(0, 3) == 0) begin
          i_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      i_valid = 1'b1;
      i_x     = frame_pix[p];
      i_last  = (p == h * W - 1) || (p == fake_last_at);
      t = 0;
      @(negedge clk);
      while (!o_ready && t < 5000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 5000) begin
        check("accept_timeout", 0, 1);
        i_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_last  = 1'b0;
      if (p == gap_at) begin
        for (int g = 0; g < 10; g++) begin
          @(negedge clk);
          if (g > 0) check("gap_ovalid", o_valid, 0);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard, hold-under-stall and frame-boundary checks.
  initial begin
    beat_t e;
    int    h;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_stall) begin
          check("hold_vld", o_valid, 1);
          check("hold_x", o_x, prev_x);
          check("hold_last", o_last, prev_last);
        end
        if (after_last) check("no_idle_after_last", o_valid, 1);
        after_last = 1'b0;
        if (o_valid && i_ready) begin
          beats++;
          if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("o_x", o_x, e.x);
            check("o_last", o_last, e.last);
          end
          if (o_last) begin
            h = (exp_h.size() != 0) ? exp_h.pop_front() : -2;
            check("frame_beats", beats, (h + 2) * PW);
            beats      = 0;
            after_last = 1'b1;
            last_cnt++;
          end
        end
        prev_stall = o_valid && !i_ready;
        prev_x     = o_x;
        prev_last  = o_last;
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted with %0d beats still expected", exp_q.size());
    $fatal(1);
  end

  initial begin
    int lc;
    reset   = 1'b0;
    i_valid = 1'b0;
    i_x     = '0;
    i_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ovalid", o_valid, 0);
    check("reset_oready", o_ready, 0);
    check("reset_ox", o_x, 0);
    check("reset_olast", o_last, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    push_lead();
    mon_en = 1'b1;

    // Column-pattern 512x2 frame, downstream always ready.
    lc = last_cnt;
    fill(2, 1'b0);
    model_frame(2);
    send_frame(2, -1, -1, -1);
    drain();
    check("t1_last_count", last_cnt - lc, 1);

    // Ten idle input cycles mid-row.
    fill(2, 1'b0);
    model_frame(2);
    send_frame(2, 200, -1, -1);
    drain();

    // Random downstream backpressure.
    rand_rdy = 1'b1;
    fill(2, 1'b0);
    model_frame(2);
    send_frame(2, -1, -1, -1);
    drain();
    rand_rdy = 1'b0;

    // i_last away from the row end must not end the frame.
    fill(2, 1'b1);
    model_frame(2);
    send_frame(2, -1, -1, 100);
    drain();

    // Reset mid-frame at row 1, pixel 300, then a clean 512x1 frame.
    fill(2, 1'b1);
    model_frame(2);
    send_frame(2, -1, W + 300, -1);
    fill(1, 1'b1);
    model_frame(1);
    send_frame(1, -1, -1, -1);
    drain();

    // Two back-to-back 512x1 frames.
    lc = last_cnt;
    fill(1, 1'b1);
    model_frame(1);
    send_frame(1, -1, -1, -1);
    fill(1, 1'b1);
    model_frame(1);
    send_frame(1, -1, -1, -1);
    drain();
    check("b2b_last_count", last_cnt - lc, 2);

    // Random data with random stalls on both sides.
    rand_rdy = 1'b1;
    rand_vld = 1'b1;
    fill(3, 1'b1);
    model_frame(3);
    send_frame(3, -1, -1, -1);
    drain();
    rand_rdy = 1'b0;
    rand_vld = 1'b0;

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_pad.md
CONV_PAD -- requirements
Module: conv_pad

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 512, unpadded pixels per row.
REQ-002 SHALL have parameter PIXEL_DATAW, default 8, pixel bit width.
REQ-003 SHALL have port clk, input, 1, the single operating clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port i_valid, input, 1, upstream pixel valid.
REQ-006 SHALL have port i_x, input, PIXEL_DATAW, raw unsigned pixel.
REQ-007 SHALL have port i_last, input, 1, qualifies the final pixel of a frame.
REQ-008 SHALL have port o_ready, output, 1, ready to accept a raw pixel.
REQ-009 SHALL have port i_ready, input, 1, downstream convolver ready.
REQ-010 SHALL have port o_valid, output, 1, padded pixel valid.
REQ-011 SHALL have port o_x, output, PIXEL_DATAW, padded pixel value.
REQ-012 SHALL have port o_last, output, 1, marks the final beat of the bottom pad row.

Function
REQ-013 SHALL convert each raw frame (IMAGE_WIDTH wide, any height H) into a zero-padded frame of H+2 rows, each IMAGE_WIDTH+2 wide, for the 3x3 convolver.
REQ-014 SHALL transfer an input beat when i_valid && o_ready, and an output beat when o_valid && i_ready.
REQ-015 SHALL use a single output register that loads when advance = !o_valid || i_ready, and holds o_x/o_valid/o_last otherwise.
REQ-016 SHALL drive o_ready = (state == BODY) && advance, combinationally.
REQ-017 SHALL implement the FSM states TOP, LEFT, BODY, RIGHT, BOTTOM, with a column counter col (0..IMAGE_WIDTH+1) that steps only on advance cycles that produce a beat.
REQ-018 In TOP, SHALL emit IMAGE_WIDTH+2 zero beats with no input consumed, then go to LEFT.
REQ-019 In LEFT, SHALL emit one zero beat, then go to BODY.
REQ-020 In BODY, SHALL pass each accepted i_x to o_x unchanged; an advance cycle without an input transfer SHALL load o_valid=0 and leave state and col unchanged.
REQ-021 After IMAGE_WIDTH accepted pixels in BODY, SHALL go to RIGHT.
REQ-022 In RIGHT, SHALL emit one zero beat, then go to BOTTOM if the row's last pixel carried i_last=1, else to LEFT.
REQ-023 SHALL ignore i_last on any pixel other than the row's final (column IMAGE_WIDTH-1) pixel.
REQ-024 In BOTTOM, SHALL emit IMAGE_WIDTH+2 zero beats, assert o_last with the final one, then go to TOP.
REQ-025 SHALL add a latency of exactly 1 cycle from an input transfer to o_valid for that pixel.
REQ-026 SHALL keep o_valid stable and o_x unchanged while o_valid && !i_ready (no drop, no duplicate).

Reset
REQ-027 On reset==0 at a clk edge: state=TOP, col=0, o_valid=0, o_x=0, o_last=0; o_ready SHALL therefore be 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first output after release SHALL be the TOP zero row.
REQ-029 Reset SHALL take priority over all handshakes in the same cycle.

Structure
REQ-030 Package conv_pkg SHALL hold PIXEL_DATAW, IMAGE_WIDTH, PADDED_WIDTH (=IMAGE_WIDTH+2), FILTER_SIZE and the pad FSM state enum.
REQ-031 The block SHALL be flat, with no sub-module; col SHALL be $clog2(PADDED_WIDTH) bits (10 for default).

Verification
REQ-032 Hold i_ready=1 after reset and send one 512x2 frame, pixel value = column mod 256, i_last on the 1024th pixel -> exactly 4x514 output beats; rows 0 and 3 all zero; rows 1-2 read 0,0,1..255,0..255,0; o_last asserted only on beat 2056.
REQ-033 Set i_valid=0 for 10 cycles mid-BODY -> o_valid=0 for those cycles; the padded sequence continues with no gap corruption; the total beat count is unchanged.
REQ-034 Toggle i_ready 1/0 randomly (50%) across a full frame -> output sequence identical to REQ-032; o_x held steady whenever o_valid && !i_ready.
REQ-035 Drive i_last=1 on pixel 100 of row 0 and on pixel 511 of row 1 -> i_last on pixel 100 ignored; frame ends after row 1 with one bottom zero row.
REQ-036 Drive reset=0 for one cycle at pixel 300 of row 1 -> o_valid=0 the next cycle; output restarts with 514 zeros; o_ready=0 until LEFT completes.
REQ-037 Send two back-to-back 512x1 frames -> output is 3x514 beats per frame (TOP, data, BOTTOM each); o_last fires twice; the second frame's TOP row follows its BOTTOM row with no idle cycle while i_ready=1.
